// File: rtl/reg_trigger_delay_if.sv
// reg_trigger_delay_if: shared register bus between the bus master and this peripheral
interface reg_trigger_delay_if;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        reg_stream;
  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_size, reg_read, reg_write, reg_addrvalid, reg_hypaddress,
    input  reg_datao, reg_hyplen, reg_stream
  );
  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_size, reg_read, reg_write, reg_addrvalid, reg_hypaddress,
    output reg_datao, reg_hyplen, reg_stream
  );
endinterface

// File: rtl/reg_trigger_delay.sv
// reg_trigger_delay: programmable delayed, width-controlled trigger pulse on the register bus
module reg_trigger_delay #(
  parameter logic [5:0] REG_CFG  = 6'd36,
  parameter logic [5:0] REG_STAT = 6'd37
) (
  input  logic                      clk,
  input  logic                      reset_i,
  reg_trigger_delay_if.slave        bus,
  input  logic                      trigger_i,
  output logic                      trigger_delayed_o,
  output logic                      armed_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DELAY = 2'd2, PULSE = 2'd3} state_t;
  state_t      state_q, state_d;
  logic [31:0] delay_q, dly_q, dly_d;
  logic [15:0] width_q, wid_q, wid_d, acc_q;
  logic [7:0]  miss_q, datao_q, rdata;
  logic        enable_q, invert_q, cont_q, arm_q, out_q;
  logic [2:0]  sync_q;
  logic        trig_edge, wr_cfg, clr_stat, acc_inc, miss_inc;
  logic [55:0] cfg_w, cfg_sh;
  logic [31:0] stat_w, stat_sh;
  logic        unused_size;
  assign unused_size = ^bus.reg_size;
  assign wr_cfg   = bus.reg_write & bus.reg_addrvalid & (bus.reg_address == REG_CFG);
  assign clr_stat = bus.reg_write & bus.reg_addrvalid & (bus.reg_address == REG_STAT);
  assign trig_edge = sync_q[1] & ~sync_q[2];
  assign miss_inc  = trig_edge & ((state_q == DELAY) | (state_q == PULSE));
  assign armed_o   = state_q == ARMED;
  assign trigger_delayed_o = out_q;
  assign bus.reg_datao  = datao_q;
  assign bus.reg_stream = 1'b0;
  assign bus.reg_hyplen = bus.reg_hypaddress == REG_CFG  ? 16'd7 :
                          bus.reg_hypaddress == REG_STAT ? 16'd4 : 16'd0;
  // live configuration; arm is a one-cycle strobe raised by the write itself
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      delay_q  <= '0;
      width_q  <= '0;
      enable_q <= 1'b0;
      invert_q <= 1'b0;
      cont_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      arm_q <= wr_cfg && bus.reg_bytecnt == 16'd6 && bus.reg_datai[3];
      if (wr_cfg)
        case (bus.reg_bytecnt)
          16'd0: delay_q[7:0]   <= bus.reg_datai;
          16'd1: delay_q[15:8]  <= bus.reg_datai;
          16'd2: delay_q[23:16] <= bus.reg_datai;
          16'd3: delay_q[31:24] <= bus.reg_datai;
          16'd4: width_q[7:0]   <= bus.reg_datai;
          16'd5: width_q[15:8]  <= bus.reg_datai;
          16'd6: {cont_q, invert_q, enable_q} <= bus.reg_datai[2:0];
          default: ;
        endcase
    end
  end
  // three-flop synchroniser feeding the rising-edge detector
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) sync_q <= '0;
    else sync_q <= {sync_q[1:0], trigger_i};
  end
  // state, shadow counters and the registered output
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      dly_q   <= '0;
      wid_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      out_q   <= ((state_q == PULSE) & enable_q) ^ invert_q;
    end
  end
  // next state: dropping enable forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    acc_inc = 1'b0;
    if (!enable_q) state_d = IDLE;
    else
      case (state_q)
        IDLE:  state_d = (arm_q | cont_q) ? ARMED : IDLE;
        ARMED: if (trig_edge) begin
          dly_d   = delay_q;
          wid_d   = width_q == 16'd0 ? 16'd1 : width_q;
          acc_inc = 1'b1;
          state_d = delay_q == 32'd0 ? PULSE : DELAY;
        end
        DELAY: if (dly_q == 32'd1) state_d = PULSE;
          else dly_d = dly_q - 32'd1;
        PULSE: if (wid_q == 16'd1) state_d = cont_q ? ARMED : IDLE;
          else wid_d = wid_q - 16'd1;
        default: state_d = IDLE;
      endcase
  end
  // saturating statistics; a clear beats a simultaneous increment
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      acc_q  <= '0;
      miss_q <= '0;
    end else begin
      acc_q  <= clr_stat ? '0 : (acc_inc && acc_q != 16'hFFFF) ? acc_q + 16'd1 : acc_q;
      miss_q <= clr_stat ? '0 : (miss_inc && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
    end
  end
  assign cfg_w   = {4'b0, arm_q, cont_q, invert_q, enable_q, width_q, delay_q};
  assign stat_w  = {miss_q, acc_q, 6'b0, state_q};
  assign cfg_sh  = cfg_w >> {bus.reg_bytecnt[2:0], 3'b000};
  assign stat_sh = stat_w >> {bus.reg_bytecnt[1:0], 3'b000};
  assign rdata   = (bus.reg_address == REG_CFG  && bus.reg_bytecnt < 16'd7) ? cfg_sh[7:0] :
                   (bus.reg_address == REG_STAT && bus.reg_bytecnt < 16'd4) ? stat_sh[7:0] : 8'h00;
  // registered read data, zero whenever this block is not being read
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) datao_q <= '0;
    else datao_q <= (bus.reg_read & bus.reg_addrvalid) ? rdata : 8'h00;
  end
endmodule

// File: tb/tb_reg_trigger_delay.sv
// tb_reg_trigger_delay: directed checks of the delayed trigger peripheral
module tb_reg_trigger_delay;
  logic clk = 1'b0, reset_i = 1'b0, trigger_i = 1'b0;
  logic trigger_delayed_o, armed_o;
  int   errors = 0, checks = 0, ones = 0;
  logic hist [0:127];
  logic [7:0] rv;
  reg_trigger_delay_if bus();
  reg_trigger_delay dut (
    .clk(clk),
    .reset_i(reset_i),
    .bus(bus),
    .trigger_i(trigger_i),
    .trigger_delayed_o(trigger_delayed_o),
    .armed_o(armed_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
    bus.reg_address = a;
    bus.reg_bytecnt = b;
    bus.reg_datai = d;
    bus.reg_write = 1'b1;
    bus.reg_addrvalid = 1'b1;
    tick();
    bus.reg_write = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask
  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [15:0] b, input logic [31:0] exp);
    bus.reg_address = a;
    bus.reg_bytecnt = b;
    bus.reg_read = 1'b1;
    bus.reg_addrvalid = 1'b1;
    tick();
    rv = bus.reg_datao;
    bus.reg_read = 1'b0;
    bus.reg_addrvalid = 1'b0;
    check(tag, 32'(rv), exp);
  endtask
  task automatic capture(input int n, input int t2);
    ones = 0;
    trigger_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      hist[k] = trigger_delayed_o;
      ones += int'(trigger_delayed_o);
      trigger_i = (k + 1 <= 1) || (k + 1 == t2) || (k + 1 == t2 + 1);
    end
    trigger_i = 1'b0;
  endtask
  initial begin
    bus.reg_address = '0;
    bus.reg_bytecnt = '0;
    bus.reg_datai = '0;
    bus.reg_size = '0;
    bus.reg_read = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_addrvalid = 1'b0;
    bus.reg_hypaddress = '0;
    tick();
    tick();
    check("rst_out", 32'(trigger_delayed_o), 0);
    check("rst_armed", 32'(armed_o), 0);
    check("rst_datao", 32'(bus.reg_datao), 0);
    check("stream", 32'(bus.reg_stream), 0);
    reset_i = 1'b1;
    bus.reg_hypaddress = 6'd36;
    #1 check("hyplen_cfg", 32'(bus.reg_hyplen), 7);
    bus.reg_hypaddress = 6'd37;
    #1 check("hyplen_stat", 32'(bus.reg_hyplen), 4);
    bus.reg_hypaddress = 6'd5;
    #1 check("hyplen_none", 32'(bus.reg_hyplen), 0);
    tick();
    chk_rd("rst_cfg6", 6'd36, 16'd6, 0);
    // basic pulse: delay 10, width 4
    wr(6'd36, 16'd0, 8'd10);
    wr(6'd36, 16'd4, 8'd4);
    wr(6'd36, 16'd6, 8'h09);
    tick();
    check("basic_armed", 32'(armed_o), 1);
    chk_rd("basic_state", 6'd37, 16'd0, 1);
    chk_rd("cfg_delay_rd", 6'd36, 16'd0, 10);
    capture(20, 0);
    check("basic_h12", 32'(hist[12]), 0);
    check("basic_h13", 32'(hist[13]), 1);
    check("basic_h16", 32'(hist[16]), 1);
    check("basic_h17", 32'(hist[17]), 0);
    check("basic_ones", 32'(ones), 4);
    chk_rd("basic_idle", 6'd37, 16'd0, 0);
    chk_rd("basic_acc", 6'd37, 16'd1, 1);
    chk_rd("basic_miss", 6'd37, 16'd3, 0);
    // zero delay and width give a single cycle after N+3
    wr(6'd36, 16'd0, 8'd0);
    wr(6'd36, 16'd4, 8'd0);
    wr(6'd36, 16'd6, 8'h09);
    tick();
    capture(10, 0);
    check("zero_h2", 32'(hist[2]), 0);
    check("zero_h3", 32'(hist[3]), 1);
    check("zero_h4", 32'(hist[4]), 0);
    check("zero_ones", 32'(ones), 1);
    chk_rd("zero_acc", 6'd37, 16'd1, 2);
    wr(6'd37, 16'd0, 8'd0);
    chk_rd("clr_acc", 6'd37, 16'd1, 0);
    // continuous mode, second trigger lands in DELAY
    wr(6'd36, 16'd0, 8'd50);
    wr(6'd36, 16'd4, 8'd2);
    wr(6'd36, 16'd6, 8'h05);
    tick();
    check("cont_armed", 32'(armed_o), 1);
    capture(80, 20);
    check("miss_h52", 32'(hist[52]), 0);
    check("miss_h53", 32'(hist[53]), 1);
    check("miss_h54", 32'(hist[54]), 1);
    check("miss_h55", 32'(hist[55]), 0);
    check("miss_ones", 32'(ones), 2);
    check("rearm", 32'(armed_o), 1);
    capture(60, 0);
    check("third_h53", 32'(hist[53]), 1);
    check("third_ones", 32'(ones), 2);
    chk_rd("cont_acc_lo", 6'd37, 16'd1, 2);
    chk_rd("cont_acc_hi", 6'd37, 16'd2, 0);
    chk_rd("cont_miss", 6'd37, 16'd3, 1);
    // disable while counting down
    wr(6'd36, 16'd0, 8'd20);
    capture(5, 0);
    wr(6'd36, 16'd6, 8'h00);
    ones = 0;
    repeat (30) begin
      tick();
      ones += int'(trigger_delayed_o);
    end
    check("dis_ones", 32'(ones), 0);
    check("dis_armed", 32'(armed_o), 0);
    chk_rd("dis_state", 6'd37, 16'd0, 0);
    chk_rd("dis_acc", 6'd37, 16'd1, 3);
    // missed counter saturates during a long delay
    wr(6'd36, 16'd0, 8'hE8);
    wr(6'd36, 16'd1, 8'h03);
    wr(6'd36, 16'd6, 8'h09);
    tick();
    check("sat_armed", 32'(armed_o), 1);
    repeat (300) begin
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      tick();
    end
    chk_rd("sat_state", 6'd37, 16'd0, 2);
    chk_rd("sat_miss", 6'd37, 16'd3, 8'hFF);
    chk_rd("sat_acc", 6'd37, 16'd1, 4);
    wr(6'd36, 16'd6, 8'h00);
    tick();
    wr(6'd37, 16'd3, 8'hAA);
    for (int b = 0; b < 4; b++) chk_rd($sformatf("clr_b%0d", b), 6'd37, 16'(b), 0);
    // async reset during an inverted pulse
    wr(6'd36, 16'd0, 8'd0);
    wr(6'd36, 16'd1, 8'd0);
    wr(6'd36, 16'd4, 8'd20);
    wr(6'd36, 16'd6, 8'h0B);
    tick();
    check("inv_idle", 32'(trigger_delayed_o), 1);
    capture(6, 0);
    check("inv_h2", 32'(hist[2]), 1);
    check("inv_h3", 32'(hist[3]), 0);
    check("inv_h5", 32'(hist[5]), 0);
    chk_rd("inv_state", 6'd37, 16'd0, 3);
    #2 reset_i = 1'b0;
    #1 check("rst_async_out", 32'(trigger_delayed_o), 0);
    check("rst_async_armed", 32'(armed_o), 0);
    tick();
    reset_i = 1'b1;
    chk_rd("rst_cfg_b6", 6'd36, 16'd6, 0);
    chk_rd("rst_cfg_b4", 6'd36, 16'd4, 0);
    capture(10, 0);
    check("rst_no_out", 32'(ones), 0);
    // unaddressed and out-of-range reads
    chk_rd("rd_unaddr", 6'd5, 16'd0, 0);
    chk_rd("rd_oob", 6'd36, 16'd7, 0);
    chk_rd("rd_stat_oob", 6'd37, 16'd4, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
